// File: rtl/fpu_issuer_pkg.sv
// fpu_issuer_pkg: shared entry/state types, opcode constants and the flag-op helper.
// FPU_OP_WIDTH, FPU_OPFCLT and FPU_OPFCZ get defaults here unless the FPU build defines them.
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 4
`endif
`ifndef FPU_OPFCLT
`define FPU_OPFCLT 8
`endif
`ifndef FPU_OPFCZ
`define FPU_OPFCZ 9
`endif
package fpu_issuer_pkg;
  localparam int OP_W = `FPU_OP_WIDTH;
  localparam int TAG_MAX = 16;
  localparam logic [OP_W-1:0] OP_FCLT = OP_W'(`FPU_OPFCLT);
  localparam logic [OP_W-1:0] OP_FCZ = OP_W'(`FPU_OPFCZ);
  // tag field sized for the widest supported TAG_WIDTH; narrower tags are zero-extended
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [TAG_MAX-1:0] tag;
  } issue_entry_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic is_flag_op(input logic [OP_W-1:0] op);
    return op == OP_FCLT || op == OP_FCZ;
  endfunction
endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: request FIFO with wrapping pointers and an occupancy count; caller gates push/pop.
module fpu_issue_fifo import fpu_issuer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type entry_t = issue_entry_t
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   empty,
  output logic   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign dout = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fpu_issuer.sv
// fpu_issuer: buffers FP requests, issues them one at a time to the FPU and returns tagged results.
// Define FPU_ISSUER_TIMEOUT_EN to bound the wait for fpu_valid by TIMEOUT_CYCLES.
module fpu_issuer import fpu_issuer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [31:0]          req_x1,
  input  logic [31:0]          req_x2,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 fpu_ready,
  output logic [OP_W-1:0]      fpu_op,
  output logic [31:0]          fpu_x1,
  output logic [31:0]          fpu_x2,
  input  logic                 fpu_valid,
  input  logic [31:0]          fpu_y32,
  input  logic                 fpu_y1,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [31:0]          wb_data,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic                 wb_err
);
  state_t state, nxt;
  issue_entry_t req, head, iss, cur;
  logic empty, full, push, pop, cap, tmo;
  assign req = '{op: req_op, x1: req_x1, x2: req_x2, tag: TAG_MAX'(req_tag)};
  assign req_ready = !full;
  assign push = req_valid && !full;
  fpu_issue_fifo #(.DEPTH(DEPTH), .entry_t(issue_entry_t)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .din(req),
    .dout(head), .empty(empty), .full(full)
  );
  // the head is presented directly in ISSUE so a request pushed into an idle, empty FIFO issues next cycle
  assign cur = state == ISSUE ? head : iss;
  assign fpu_ready = state == ISSUE;
  assign fpu_op = cur.op;
  assign fpu_x1 = cur.x1;
  assign fpu_x2 = cur.x2;
  assign wb_valid = state == RESP;
`ifdef FPU_ISSUER_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wait_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) wait_cnt <= '0;
    else wait_cnt <= state == ISSUE ? '0 : state == WAIT ? wait_cnt + 1'b1 : wait_cnt;
  assign tmo = state == WAIT && !fpu_valid && wait_cnt == WCW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: nxt = (!empty || push) ? ISSUE : IDLE;
      ISSUE: begin
        pop = 1'b1;
        cap = fpu_valid;
        nxt = fpu_valid ? RESP : WAIT;
      end
      WAIT: begin
        cap = fpu_valid;
        nxt = (fpu_valid || tmo) ? RESP : WAIT;
      end
      default: nxt = wb_ready ? (empty ? IDLE : ISSUE) : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      iss <= '0;
      wb_data <= '0;
      wb_tag <= '0;
      wb_err <= 1'b0;
    end else begin
      state <= nxt;
      if (pop) iss <= head;
      if (cap) begin
        wb_data <= is_flag_op(cur.op) ? {31'b0, fpu_y1} : fpu_y32;
        wb_tag <= cur.tag[TAG_WIDTH-1:0];
        wb_err <= 1'b0;
      end else if (tmo) begin
        wb_data <= '0;
        wb_tag <= iss.tag[TAG_WIDTH-1:0];
        wb_err <= 1'b1;
      end
    end
endmodule
